// File: rtl/double_trouble_sweeper.sv
// In-hardware stimulus/check engine for the 4-input "at least N of 4" block.
// Sweeps {d,c,b,a} over 0..15, samples out_in, and reports pass/fail results.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a sweep (only honoured in IDLE)
//   out_in          response from the block under test
//   a, b, c, d      stimulus bits 0..3
//   busy, done      sweep in progress / one-cycle completion pulse
//   pass            last sweep had no mismatches
//   err_count       mismatching vectors (0..16)
//   first_err_idx   first mismatching vector (0 when none)
//   mismatch_map    bit i set when vector i mismatched
module double_trouble_sweeper #(
    parameter int THRESHOLD     = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        out_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_idx,
    output logic [15:0] mismatch_map
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    // WAIT lasts exactly SETTLE_CYCLES cycles: load N-1, leave on zero.
    localparam logic [3:0] WAIT_LOAD =
        4'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [2:0] TH = 3'(THRESHOLD);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] wcnt;
    logic [2:0] ones;
    logic       expected;
    logic       miss;

    assign ones = 3'(idx[0]) + 3'(idx[1]) + 3'(idx[2]) + 3'(idx[3]);
    assign expected = (ones >= TH);
    assign miss = (out_in != expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= 4'd0;
            wcnt          <= 4'd0;
            {d, c, b, a}  <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 5'd0;
            first_err_idx <= 4'd0;
            mismatch_map  <= 16'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    {d, c, b, a} <= 4'd0;
                    busy         <= 1'b0;
                    if (start) begin
                        idx           <= 4'd0;
                        err_count     <= 5'd0;
                        first_err_idx <= 4'd0;
                        mismatch_map  <= 16'd0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    {d, c, b, a} <= idx;
                    wcnt         <= WAIT_LOAD;
                    state        <= (SETTLE_CYCLES > 0) ? S_WAIT : S_SAMPLE;
                end
                S_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (miss) begin
                        err_count         <= err_count + 5'd1;
                        mismatch_map[idx] <= 1'b1;
                        if (err_count == 5'd0) begin
                            first_err_idx <= idx;
                        end
                    end
                    // Vector 15 ends the sweep; idx never wraps into DRIVE.
                    if (idx == 4'd15) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    pass         <= (err_count == 5'd0);
                    {d, c, b, a} <= 4'd0;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_trouble_sweeper.sv
// Scoreboard bench for double_trouble_sweeper: two instances (default and
// THRESHOLD=3/SETTLE=0) driven by truth-table models of the block under test.
module tb_double_trouble_sweeper;

    localparam int LIM = 400;

    typedef struct {
        logic        pass;
        logic [4:0]  err;
        logic [3:0]  first;
        logic [15:0] map;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_w [2];
    logic        out_w   [2];
    logic        a_w     [2];
    logic        b_w     [2];
    logic        c_w     [2];
    logic        d_w     [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        pass_w  [2];
    logic [4:0]  err_w   [2];
    logic [3:0]  first_w [2];
    logic [15:0] map_w   [2];
    logic [15:0] tbl_w   [2];

    int   total;
    int   passed;
    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    int   cyc[2];
    int   nvec[2];
    int   lastv[2];
    bit   seqok[2];
    bit   bprev[2];
    bit   pend[2];
    int   done_cnt[2];
    int   qsz;
    logic [3:0] mv;

    double_trouble_sweeper u_dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .out_in(out_w[0]),
        .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .first_err_idx(first_w[0]),
        .mismatch_map(map_w[0])
    );

    double_trouble_sweeper #(.THRESHOLD(3), .SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .out_in(out_w[1]),
        .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .first_err_idx(first_w[1]),
        .mismatch_map(map_w[1])
    );

    // Block under test modelled as a truth table indexed by {d,c,b,a}.
    assign out_w[0] = tbl_w[0][{d_w[0], c_w[0], b_w[0], a_w[0]}];
    assign out_w[1] = tbl_w[1][{d_w[1], c_w[1], b_w[1], a_w[1]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int k,
                                input logic [31:0] got,
                                input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s dut%0d got %0h expected %0h", nm, k, got, exp);
        end
    endfunction

    function automatic logic [15:0] maj(input int th);
        logic [15:0] t;
        logic [3:0]  iv;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            iv   = i[3:0];
            t[i] = ($countones(iv) >= th);
        end
        return t;
    endfunction

    function automatic exp_t ref_model(input logic [15:0] tbl,
                                       input int th, input int lat);
        exp_t e;
        logic [3:0] iv;
        e.err   = '0;
        e.first = '0;
        e.map   = '0;
        e.lat   = lat;
        for (int i = 0; i < 16; i++) begin
            iv = i[3:0];
            if (tbl[i] != ($countones(iv) >= th)) begin
                if (e.err == 0) e.first = iv;
                e.err++;
                e.map[i] = 1'b1;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    function automatic void chk_rst(input int k);
        chk("rst_outputs", k,
            {a_w[k], b_w[k], c_w[k], d_w[k], busy_w[k], done_w[k],
             pass_w[k], err_w[k], first_w[k], map_w[k]}, 0);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                bprev[k] = 1'b0;
                pend[k]  = 1'b0;
                cyc[k]   = 0;
            end else begin
                if (pend[k]) begin
                    chk("pass", k, pass_w[k], cur[k].pass);
                    chk("err_count", k, err_w[k], cur[k].err);
                    chk("first_err_idx", k, first_w[k], cur[k].first);
                    chk("mismatch_map", k, map_w[k], cur[k].map);
                    pend[k] = 1'b0;
                end
                if (busy_w[k]) begin
                    if (!bprev[k]) begin
                        cyc[k]   = 1;
                        nvec[k]  = 0;
                        seqok[k] = 1'b1;
                        lastv[k] = -1;
                    end else begin
                        cyc[k]++;
                    end
                    mv = {d_w[k], c_w[k], b_w[k], a_w[k]};
                    if (int'(mv) != lastv[k]) begin
                        if (int'(mv) != nvec[k]) seqok[k] = 1'b0;
                        nvec[k]++;
                        lastv[k] = int'(mv);
                    end
                    if (cyc[k] == 10) chk("pass_mid_sweep", k, pass_w[k], 0);
                end
                if (done_w[k]) begin
                    cyc[k]++;
                    done_cnt[k]++;
                    chk("busy_in_done", k, busy_w[k], 0);
                    chk("vec_count", k, nvec[k], 16);
                    chk("vec_order", k, seqok[k], 1);
                    qsz = (k == 0) ? q0.size() : q1.size();
                    chk("done_expected", k, (qsz > 0), 1);
                    if (qsz > 0) begin
                        cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("done_latency", k, cyc[k], cur[k].lat);
                        pend[k] = 1'b1;
                    end
                end
                bprev[k] = busy_w[k];
            end
        end
    end

    task automatic wait_done(input int k, input int tgt);
        int t;
        t = 0;
        while (done_cnt[k] < tgt && t < LIM) begin
            @(posedge clk);
            t++;
        end
        chk("done_timeout", k, (t < LIM), 1);
    endtask

    task automatic sweep(input int k, input logic [15:0] tbl,
                         input int nsw, input bit poke);
        exp_t e;
        int   tgt;
        tbl_w[k] = tbl;
        e = ref_model(tbl, (k == 0) ? 2 : 3, (k == 0) ? 49 : 33);
        for (int i = 0; i < nsw; i++) begin
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        tgt = done_cnt[k] + nsw;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1 start_w[k] = 1'b1;
        if (nsw > 1) begin
            wait_done(k, tgt - 1);
        end
        @(posedge clk);
        #1 start_w[k] = 1'b0;
        if (poke) begin
            repeat (8) @(posedge clk);
            #1 start_w[k] = 1'b1;
            @(posedge clk);
            #1 start_w[k] = 1'b0;
            repeat (20) @(posedge clk);
            #1 start_w[k] = 1'b1;
            @(posedge clk);
            #1 start_w[k] = 1'b0;
        end
        wait_done(k, tgt);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int t;
        int dc;
        total       = 0;
        passed      = 0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        rst         = 1'b0;
        start_w[0]  = 1'b0;
        start_w[1]  = 1'b0;
        tbl_w[0]    = maj(2);
        tbl_w[1]    = maj(2);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst(0);
        chk_rst(1);
        rst = 1'b0;

        sweep(0, maj(2), 1, 1'b0);
        sweep(0, 16'h0000, 1, 1'b0);
        sweep(0, 16'hFFFF, 1, 1'b0);
        sweep(0, ~maj(2), 1, 1'b0);
        sweep(0, maj(2), 1, 1'b0);
        sweep(1, maj(2), 1, 1'b0);
        sweep(1, 16'(~$urandom), 1, 1'b0);
        sweep(0, 16'($urandom), 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sweep(0, 16'($urandom), 1, (i == 0));
        end

        tbl_w[0] = maj(2);
        @(posedge clk);
        #1 start_w[0] = 1'b1;
        @(posedge clk);
        #1 start_w[0] = 1'b0;
        t = 0;
        while ({d_w[0], c_w[0], b_w[0], a_w[0]} != 4'd7 && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk("reach_vec7", 0, (t < LIM), 1);
        dc = done_cnt[0];
        rst = 1'b1;
        #1 chk_rst(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst(0);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        chk("no_done_after_rst", 0, done_cnt[0] - dc, 0);
        chk("idle_after_rst", 0, {busy_w[0], pass_w[0], err_w[0]}, 0);

        sweep(0, maj(2), 1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
